// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID boundary with a DEPTH-entry {pc, inst} FIFO in front of a
// registered ID output stage. IF pushes with valid/ready; ID sees one registered
// entry per cycle under the pipeline stall vector and flush.
module if_id_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic   clear_c;
  logic   empty_c;
  logic   enq_c;
  logic   deq_c;
  logic   bubble_c;
  entry_t head_c;
  logic   stall_unused_c;

  // Only the IF/ID and ID hold bits matter at this boundary.
  assign stall_unused_c = ^{stall[5:3], stall[0]};

  // Ready depends only on the registered occupancy, never on stall or a same-cycle dequeue.
  assign if_ready = (count != CNT_W'(DEPTH));

  // Per-cycle decisions: clear beats everything, then bubble/dequeue/hold.
  always_comb begin
    clear_c  = 1'b0;
    empty_c  = 1'b0;
    enq_c    = 1'b0;
    deq_c    = 1'b0;
    bubble_c = 1'b0;
    head_c   = mem[rd_ptr];

    clear_c = !rst || flush;
    empty_c = (count == '0);
    enq_c   = !clear_c && if_valid && if_ready;
    deq_c   = !clear_c && !stall[1] && !empty_c;
    // Bubble when IF/ID is held but ID is free, or when ID is free and there is nothing to give.
    bubble_c = !clear_c && ((stall[1] && !stall[2]) || (!stall[1] && empty_c));
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      mem[wr_ptr] <= entry_t'({if_pc, if_inst});
    end
  end

  // Write/read pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (clear_c) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop cancel out.
  always_ff @(posedge clk) begin
    if (clear_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(enq_c) - CNT_W'(deq_c);
    end
  end

  // ID output register: clear, bubble, load head, or hold when both stages are stalled.
  always_ff @(posedge clk) begin
    if (clear_c) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else if (bubble_c) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else if (deq_c) begin
      id_pc    <= head_c.pc;
      id_inst  <= head_c.inst;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised + directed scoreboard bench for if_id_queue against a queue-based model.
module tb_if_id_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic [5:0]        stall;
  logic              flush;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic [CNT_W-1:0]  count;

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [CNT_W-1:0]  cnt;
    logic              rdy;
  } exp_t;

  // Reference model state: a plain queue plus the last thing handed to ID.
  ent_t              mq[$];
  logic              m_v;
  logic [ADDR_W-1:0] m_pc;
  logic [INST_W-1:0] m_inst;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_deliv  = 0;

  logic [ADDR_W-1:0] next_pc;
  logic [INST_W-1:0] next_inst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive, advance the model, queue the post-edge expectation.
  task automatic cyc(input logic r, input logic f, input logic [5:0] s, input logic v);
    logic accept;
    ent_t e;
    exp_t x;
    @(negedge clk);
    rst      = r;
    flush    = f;
    stall    = s;
    if_valid = v;
    if_pc    = next_pc;
    if_inst  = next_inst;

    accept = 1'b0;
    if (!r || f) begin
      mq.delete();
      m_v = 1'b0; m_pc = '0; m_inst = '0;
    end else begin
      accept = v && (mq.size() < DEPTH);
      if (s[1] && !s[2]) begin
        m_v = 1'b0; m_pc = '0; m_inst = '0;
      end else if (!s[1]) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          m_v = 1'b1; m_pc = e.pc; m_inst = e.inst;
          n_deliv++;
        end else begin
          m_v = 1'b0; m_pc = '0; m_inst = '0;
        end
      end
      if (accept) begin
        e.pc = next_pc; e.inst = next_inst;
        mq.push_back(e);
      end
    end
    if (accept) begin
      next_pc   = next_pc + 32'd4;
      next_inst = $urandom;
    end

    x.v    = m_v;
    x.pc   = m_pc;
    x.inst = m_inst;
    x.cnt  = CNT_W'(mq.size());
    x.rdy  = (mq.size() != DEPTH);
    exp_q.push_back(x);
  endtask

  // Monitor: compare the DUT against each queued expectation just after the edge.
  exp_t ex;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      ex = exp_q.pop_front();
      check("id_valid", 64'(id_valid), 64'(ex.v));
      check("id_pc",    64'(id_pc),    64'(ex.pc));
      check("id_inst",  64'(id_inst),  64'(ex.inst));
      check("count",    64'(count),    64'(ex.cnt));
      check("if_ready", 64'(if_ready), 64'(ex.rdy));
    end
  end

  initial begin
    int sel;
    logic [5:0] s;
    rst = 1'b0; flush = 1'b0; stall = '0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    m_v = 1'b0; m_pc = '0; m_inst = '0;
    next_pc = 32'h0; next_inst = $urandom;

    // Reset held two cycles while IF offers.
    repeat (2) cyc(1'b0, 1'b0, 6'b0, 1'b1);

    // Back-to-back stream with no stall.
    next_pc = 32'h100;
    repeat (3) cyc(1'b1, 1'b0, 6'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 6'b0, 1'b0);

    // Fill while IF/ID and ID held, then release.
    next_pc = 32'h200;
    repeat (6) cyc(1'b1, 1'b0, 6'b000110, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 6'b0, 1'b0);

    // Bubble with two entries queued.
    repeat (2) cyc(1'b1, 1'b0, 6'b000110, 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 6'b000010, 1'b0);

    // Flush with three queued and a same-cycle offer.
    cyc(1'b1, 1'b1, 6'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 6'b000110, 1'b1);
    next_pc = 32'h300;
    cyc(1'b1, 1'b1, 6'b000110, 1'b1);
    next_pc = 32'h400;
    repeat (3) cyc(1'b1, 1'b0, 6'b0, 1'b0);

    // Full plus dequeue, retry, then a long stream across several pointer wraps.
    next_pc = 32'h500;
    repeat (4) cyc(1'b1, 1'b0, 6'b000110, 1'b1);
    cyc(1'b1, 1'b0, 6'b0, 1'b1);
    cyc(1'b1, 1'b0, 6'b0, 1'b1);
    repeat (3 * DEPTH + 4) cyc(1'b1, 1'b0, 6'b0, 1'b1);
    repeat (DEPTH + 2) cyc(1'b1, 1'b0, 6'b0, 1'b0);

    // Random traffic.
    repeat (600) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       s = 6'b000000;
        1:       s = 6'b000110;
        2:       s = 6'b000010;
        default: s = 6'($urandom);
      endcase
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 29) == 0), s,
          ($urandom_range(0, 3) != 0));
    end
    repeat (DEPTH + 2) cyc(1'b1, 1'b0, 6'b0, 1'b0);

    // Bounded wait for the monitor to consume every expectation.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    n_checks++;
    if (n_deliv < 3 * DEPTH) begin
      n_err++;
      $display("FAIL deliveries: got %0d required at least %0d", n_deliv, 3 * DEPTH);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
